// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_ctrl_pkg : shared types and sizes for the LED mode controller  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_CPU   = 2'd0,
      MODE_COUNT = 2'd1,
      MODE_BTN   = 2'd2
   } led_mode_t;

   localparam int NUM_BTN = 4;
   localparam int NUM_LED = 8;
   localparam int CNT_W   = 32;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : 2-FF sync, counter debounce and press pulse, 1 bit  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_press
);

   localparam int             C_DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [C_DB_W-1:0] C_LAST = C_DB_W'(DEBOUNCE_CYCLES - 1);

   logic              r_meta;
   logic              r_sync;
   logic              r_db;
   logic              r_press;
   logic [C_DB_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= btn_raw;
         r_sync <= r_meta;
      end
   end

   // The pulse is raised on the same edge that flips r_db so both appear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db    <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_press <= 1'b0;
         if (r_sync == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == C_LAST) begin
            r_db    <= r_sync;
            r_press <= r_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign btn_db    = r_db;
   assign btn_press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_mode_ctrl : button conditioning and LED source selection       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module led_mode_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HEARTBEAT_BIT   = 24
) (
   input  logic               clk,
   input  logic               axi_aresetn,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [NUM_LED-1:0] cpu_led,
   output logic [NUM_BTN-1:0] btn_db,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_LED-1:0] led,
   output logic [1:0]         mode
);

   logic [CNT_W-1:0]   r_cnt;
   led_mode_t          r_state;
   led_mode_t          w_next;
   logic [NUM_LED-1:0] w_led;
   logic [NUM_LED-1:0] r_led;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk      (clk),
         .rst_n    (axi_aresetn),
         .btn_raw  (btn_raw[gi]),
         .btn_db   (btn_db[gi]),
         .btn_press(btn_press[gi])
      );
   end

   always_ff @(posedge clk or negedge axi_aresetn) begin
      if (!axi_aresetn) r_cnt <= '0;
      else              r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge axi_aresetn) begin
      if (!axi_aresetn) r_state <= MODE_CPU;
      else              r_state <= w_next;
   end

   // btn_press[2] is a global escape back to CPU and overrides a concurrent advance.
   always_comb begin
      w_next = r_state;
      if (btn_press[2]) begin
         w_next = MODE_CPU;
      end else begin
         case (r_state)
            MODE_CPU:   if (btn_press[3]) w_next = MODE_COUNT;
            MODE_COUNT: if (btn_press[3]) w_next = MODE_BTN;
            MODE_BTN:   if (btn_press[3]) w_next = MODE_CPU;
            default:    w_next = MODE_CPU;
         endcase
      end
   end

   always_comb begin
      w_led = '0;
      case (r_state)
         MODE_CPU:   w_led = cpu_led;
         MODE_COUNT: w_led = r_cnt[HEARTBEAT_BIT +: NUM_LED];
         MODE_BTN:   w_led = {{(NUM_LED-NUM_BTN){1'b0}}, btn_db};
         default:    w_led = '0;
      endcase
   end

   always_ff @(posedge clk or negedge axi_aresetn) begin
      if (!axi_aresetn) r_led <= '0;
      else              r_led <= w_led;
   end

   assign led  = r_led;
   assign mode = r_state;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_mode_ctrl : scoreboard bench, expectations keyed by cycle   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_led_mode_ctrl;

   localparam int S_LED  = 0;
   localparam int S_DB   = 1;
   localparam int S_PRS  = 2;
   localparam int S_MODE = 3;

   logic       clk = 1'b0;
   logic       axi_aresetn;
   logic [3:0] btn_raw;
   logic [7:0] cpu_led;
   logic [3:0] btn_db;
   logic [3:0] btn_press;
   logic [7:0] led;
   logic [1:0] mode;

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;
   int rel_cyc  = 0;

   typedef struct {
      int         due;
      int         sel;
      logic [7:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];

   led_mode_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .HEARTBEAT_BIT  (0)
   ) dut (
      .clk        (clk),
      .axi_aresetn(axi_aresetn),
      .btn_raw    (btn_raw),
      .cpu_led    (cpu_led),
      .btn_db     (btn_db),
      .btn_press  (btn_press),
      .led        (led),
      .mode       (mode)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   task automatic expect_at(input int due, input int sel, input logic [7:0] v, input string tag);
      exp_t e;
      e.due = due;
      e.sel = sel;
      e.exp = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Pop every expectation due this cycle and compare it with the live output.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            logic [7:0] got;
            case (sb[i].sel)
               S_LED:   got = led;
               S_DB:    got = {4'h0, btn_db};
               S_PRS:   got = {4'h0, btn_press};
               default: got = {6'h0, mode};
            endcase
            check(sb[i].tag, {24'h0, got}, {24'h0, sb[i].exp});
            sb.delete(i);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Debounced press of the buttons in m; other buttons assumed released.
   task automatic tap(input logic [3:0] m, input logic [7:0] mode_now,
                      input logic [7:0] mode_next, input string tag);
      int t;
      t = cyc;
      btn_raw = btn_raw | m;
      expect_at(t + 5, S_DB,   8'h00,      {tag, "_db_early"});
      expect_at(t + 5, S_PRS,  8'h00,      {tag, "_prs_early"});
      expect_at(t + 6, S_DB,   {4'h0, m},  {tag, "_db"});
      expect_at(t + 6, S_PRS,  {4'h0, m},  {tag, "_prs"});
      expect_at(t + 7, S_PRS,  8'h00,      {tag, "_prs_one"});
      expect_at(t + 6, S_MODE, mode_now,   {tag, "_mode_before"});
      expect_at(t + 7, S_MODE, mode_next,  {tag, "_mode_after"});
      step(8);
      btn_raw = btn_raw & ~m;
      expect_at(t + 14, S_DB,  8'h00, {tag, "_db_rel"});
      expect_at(t + 14, S_PRS, 8'h00, {tag, "_prs_rel"});
      expect_at(t + 15, S_PRS, 8'h00, {tag, "_prs_rel2"});
      step(12);
   endtask

   initial begin
      int t;
      int c0;
      axi_aresetn = 1'b1;
      btn_raw     = 4'hF;
      cpu_led     = 8'hA5;
      #2 axi_aresetn = 1'b0;

      // Reset state
      step(3);
      expect_at(cyc, S_LED,  8'h00, "rst_led");
      expect_at(cyc, S_DB,   8'h00, "rst_db");
      expect_at(cyc, S_PRS,  8'h00, "rst_prs");
      expect_at(cyc, S_MODE, 8'h00, "rst_mode");
      axi_aresetn = 1'b1;
      btn_raw     = 4'h0;
      rel_cyc     = cyc;
      expect_at(cyc,     S_LED,  8'h00, "rel_led0");
      expect_at(cyc + 1, S_LED,  8'hA5, "rel_led_cpu");
      expect_at(cyc + 1, S_MODE, 8'h00, "rel_mode");
      step(4);

      // Bounce on btn0 then hold
      t = cyc;
      btn_raw[0] = 1'b1; step(1);
      btn_raw[0] = 1'b0; step(1);
      btn_raw[0] = 1'b1; step(1);
      btn_raw[0] = 1'b0; step(1);
      btn_raw[0] = 1'b1;
      for (int k = t; k <= t + 9; k++) begin
         expect_at(k, S_DB,  8'h00, "bnc_db_quiet");
         expect_at(k, S_PRS, 8'h00, "bnc_prs_quiet");
      end
      expect_at(t + 10, S_DB,   8'h01, "bnc_db_rise");
      expect_at(t + 10, S_PRS,  8'h01, "bnc_prs");
      expect_at(t + 11, S_PRS,  8'h00, "bnc_prs_one");
      expect_at(t + 12, S_MODE, 8'h00, "bnc_mode");
      step(14);
      btn_raw[0] = 1'b0;
      expect_at(cyc + 6, S_DB,  8'h00, "bnc_db_rel");
      expect_at(cyc + 6, S_PRS, 8'h00, "bnc_prs_rel");
      step(10);

      // Mode cycling: COUNT, with heartbeat wrap window
      tap(4'h8, 8'd0, 8'd1, "to_count");
      c0 = cyc;
      for (int k = c0; k <= c0 + 260; k++)
         expect_at(k, S_LED, 8'(k - 1 - rel_cyc), "count_led");
      step(262);

      // BTN mode with btn1 and btn3 held
      t = cyc;
      btn_raw = 4'b1010;
      expect_at(t + 6, S_DB,   8'h0A, "btn_db");
      expect_at(t + 6, S_PRS,  8'h0A, "btn_prs");
      expect_at(t + 7, S_MODE, 8'd2,  "btn_mode");
      expect_at(t + 8, S_LED,  8'h0A, "btn_led");
      step(9);
      cpu_led = 8'h3C;
      btn_raw = 4'h0;
      expect_at(t + 10, S_LED,  8'h0A, "btn_led_no_cpu");
      expect_at(t + 16, S_LED,  8'h00, "btn_led_rel");
      expect_at(t + 16, S_MODE, 8'd2,  "btn_mode_hold");
      step(12);

      // Back to CPU; stale GPIO write is not shown, new one is
      tap(4'h8, 8'd2, 8'd0, "to_cpu");
      expect_at(cyc,     S_LED, 8'h3C, "cpu_led_cur");
      cpu_led = 8'h5A;
      expect_at(cyc + 1, S_LED, 8'h5A, "cpu_led_lat1");
      step(3);

      // Simultaneous btn2+btn3 from COUNT
      tap(4'h8, 8'd0, 8'd1, "to_count2");
      tap(4'hC, 8'd1, 8'd0, "simul");

      // Short glitch on btn2 while in COUNT
      tap(4'h8, 8'd0, 8'd1, "to_count3");
      t = cyc;
      btn_raw[2] = 1'b1;
      for (int k = t; k <= t + 12; k++) begin
         expect_at(k, S_DB,   8'h00, "glt_db");
         expect_at(k, S_PRS,  8'h00, "glt_prs");
         expect_at(k, S_MODE, 8'd1,  "glt_mode");
      end
      step(3);
      btn_raw[2] = 1'b0;
      step(14);

      // Reset mid-debounce
      t = cyc;
      btn_raw = 4'b0010;
      step(4);
      axi_aresetn = 1'b0;
      expect_at(cyc, S_MODE, 8'd0,  "mid_rst_mode");
      expect_at(cyc, S_LED,  8'h00, "mid_rst_led");
      expect_at(cyc, S_DB,   8'h00, "mid_rst_db");
      expect_at(cyc, S_PRS,  8'h00, "mid_rst_prs");
      step(2);
      axi_aresetn = 1'b1;
      t = cyc;
      for (int k = t; k <= t + 5; k++) begin
         expect_at(k, S_DB,  8'h00, "mid_db_wait");
         expect_at(k, S_PRS, 8'h00, "mid_prs_wait");
      end
      expect_at(t + 6, S_DB,   8'h02, "mid_db_rise");
      expect_at(t + 6, S_PRS,  8'h02, "mid_prs");
      expect_at(t + 7, S_PRS,  8'h00, "mid_prs_one");
      expect_at(t + 7, S_MODE, 8'd0,  "mid_mode");
      step(10);
      btn_raw = 4'h0;
      step(10);

      check("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
